// File: rtl/mux_n_to_1_rr.sv
// N-channel streaming multiplexer with valid/ready handshakes and a single
// registered output stage; round-robin or fixed-priority arbitration, plus force mode.
module mux_n_to_1_rr #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int SEL_W     = 2,
  parameter int FIXED_PRI = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int NP = 1 << SEL_W;

  logic [W-1:0]     out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  logic             load;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   rr_sum;

  // Channels padded out to the full index range so any SEL_W index is legal;
  // padding channels are never valid, which also rejects force_sel >= N.
  logic [NP-1:0]    valid_pad;
  logic [W-1:0]     word_pad [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_pad
      if (gi < N) begin : g_real
        assign valid_pad[gi] = in_valid[gi];
        assign word_pad[gi]  = in_data[gi*W +: W];
      end else begin : g_fill
        assign valid_pad[gi] = 1'b0;
        assign word_pad[gi]  = '0;
      end
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    if (force_en) begin
      grant_idx   = force_sel;
      grant_found = valid_pad[force_sel];
    end else if (FIXED_PRI != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (valid_pad[SEL_W'(i)]) begin
          grant_found = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Search ptr, ptr+1, ... wrapping at N; first valid channel wins.
      for (int i = 0; i < N; i++) begin
        rr_sum = {1'b0, ptr_reg} + (SEL_W+1)'(i);
        if (rr_sum >= (SEL_W+1)'(N))
          rr_sum = rr_sum - (SEL_W+1)'(N);
        if (!grant_found && valid_pad[rr_sum[SEL_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = rr_sum[SEL_W-1:0];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = load && grant_found && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (grant_found) begin
        out_data_reg  <= word_pad[grant_idx];
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (!force_en && FIXED_PRI == 0)
          ptr_reg <= ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule
